mips_controller: RTL and testbench
==================================

MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 Parameters: none; opcode, funct and state encodings are shared constants, not parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces state FETCH1 immediately.
REQ-004 op  in  6  instr[31:26] from the datapath.
REQ-005 funct  in  6  instr[5:0] from the datapath.
REQ-006 zero  in  1  ALU zero flag, combinational from the datapath.
REQ-007 pcen, iord, regdst, memtoreg, regwrite, alusrca, memread, memwrite  out  1 each  datapath/memory controls.
REQ-008 irwrite  out  4  instruction-register byte enables, at most one bit set.
REQ-009 alusrcb  out  2  ALU B select: 00 reg, 01 const 1, 10 imm, 11 imm*4.
REQ-010 pcsource  out  2  next-PC select: 00 aluout, 01 aluout_flop, 10 immx4.
REQ-011 alucont  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 state  out  4  current state code, debug only.

Function
REQ-013 Multicycle Moore FSM; outputs decode from state only, except pcen in BEQEX (zero) and alucont in RTYPEEX (funct).
REQ-014 State codes: FETCH1-4=0-3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14; code 15 goes to FETCH1 next cycle with all strobes 0.
REQ-015 Unlisted outputs are 0 in every state; alucont defaults to 010.
REQ-016 FETCHn: memread=1, iord=0, alusrca=0, alusrcb=01, alucont=add, pcsource=00, pcen=1; irwrite = 1000, 0100, 0010, 0001 for FETCH1-4; FETCHn -> FETCHn+1, FETCH4 -> DECODE.
REQ-017 DECODE: alusrca=0, alusrcb=11, add (branch target into aluout_flop); next by op: LB 100000 or SB 101000 -> MEMADR; R-type 000000 -> RTYPEEX; BEQ 000100 -> BEQEX; J 000010 -> JEX; ADDI 001000 -> ADDIEX; other -> FETCH1.
REQ-018 MEMADR: alusrca=1, alusrcb=10, add; LB -> LBRD, SB -> SBWR.
REQ-019 LBRD: MEMADR ALU controls held, iord=1, memread=1 -> LBWR.
REQ-020 LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
REQ-021 SBWR: MEMADR ALU controls held, iord=1, memwrite=1 -> FETCH1.
REQ-022 RTYPEEX: alusrca=1, alusrcb=00; alucont from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other add; -> RTYPEWR.
REQ-023 RTYPEWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
REQ-024 BEQEX: alusrca=1, alusrcb=00, sub, pcsource=01, pcen=zero -> FETCH1.
REQ-025 JEX: pcsource=10, pcen=1 -> FETCH1.
REQ-026 ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWR; ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH1.
REQ-027 Cycles per instruction: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6, illegal op 5.
REQ-028 memread and memwrite never both 1; regwrite and memwrite never both 1.

Reset
REQ-029 reset low: state=FETCH1 asynchronously; all 1-bit outputs, irwrite, alusrcb, pcsource 0; alucont 010; state output 0.
REQ-030 Reset mid-instruction aborts it with no further strobes; first edge after release executes FETCH1 (pcen=1, irwrite=1000).

Structure
REQ-031 Shared package holds opcode, funct, alucont and state-code constants.
REQ-032 One sub-module, alu_decoder: (aluop[1:0], funct) -> alucont, combinational; aluop 00 add, 01 sub, 10 funct.

Verification
REQ-033 Reset low mid-MEMADR, release -> state=0, pcen=0 during reset; next edge FETCH1 strobes, irwrite 1000,0100,0010,0001.
REQ-034 op=100000 -> state sequence 0,1,2,3,4,5,6,7,0; memread=1,iord=1 in 6; regwrite=1,memtoreg=1 in 7.
REQ-035 op=000000, funct=101010 -> alucont=111 in RTYPEEX, regdst=1,regwrite=1 in RTYPEWR, 7 cycles.
REQ-036 op=000100: zero=1 -> pcen=1,pcsource=01 in BEQEX; zero=0 -> pcen=0; both return to FETCH1.
REQ-037 op=101000 -> memwrite=1,iord=1 in SBWR only; op=111111 -> DECODE then FETCH1, no regwrite/memwrite.

Source files
------------

// File: rtl/mips_controller_pkg.sv
// ---------------------------------------------------------------------------
// mips_controller_pkg
// Shared constants for the multicycle MIPS controller: instruction opcodes,
// R-type function codes, ALU control codes, ALU-op classes, datapath mux
// selects and the FSM state codes (exported on the debug state port).
// ---------------------------------------------------------------------------
package mips_controller_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_FLOP = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef enum logic [3:0] {
        FETCH1   = 4'd0,
        FETCH2   = 4'd1,
        FETCH3   = 4'd2,
        FETCH4   = 4'd3,
        DECODE   = 4'd4,
        MEMADR   = 4'd5,
        LBRD     = 4'd6,
        LBWR     = 4'd7,
        SBWR     = 4'd8,
        RTYPEEX  = 4'd9,
        RTYPEWR  = 4'd10,
        BEQEX    = 4'd11,
        JEX      = 4'd12,
        ADDIEX   = 4'd13,
        ADDIWR   = 4'd14,
        BADSTATE = 4'd15
    } state_t;

    // Instruction-register byte enable for fetch cycle idx (0..3):
    // the most significant byte is loaded first.
    function automatic logic [3:0] fetch_irwrite(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/mips_controller_if.sv
// ---------------------------------------------------------------------------
// mips_controller_if
// Controller <-> datapath/memory bundle.
//   From datapath : op[5:0], funct[5:0], zero
//   To datapath   : pcen, iord, regdst, memtoreg, regwrite, alusrca,
//                   memread, memwrite, irwrite[3:0], alusrcb[1:0],
//                   pcsource[1:0], alucont[2:0], state[3:0] (debug)
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mips_controller_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       memread;
    logic       memwrite;
    logic [3:0] irwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [2:0] alucont;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, iord, regdst, memtoreg, regwrite, alusrca, memread,
               memwrite, irwrite, alusrcb, pcsource, alucont, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, regdst, memtoreg, regwrite, alusrca, memread,
               memwrite, irwrite, alusrcb, pcsource, alucont, state
    );

endinterface

// File: rtl/mips_controller_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   aluop_i[1:0] : 00 add, 01 sub, 10 take operation from funct_i
//   funct_i[5:0] : R-type function field
//   alucont_o[2:0]: ALU function code
// Unknown funct values and aluop 11 fall back to add.
// ---------------------------------------------------------------------------
module alu_decoder
    import mips_controller_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucont_o
);

    always_comb begin
        alucont_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucont_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucont_o = ALU_ADD;
                    FN_SUB:  alucont_o = ALU_SUB;
                    FN_AND:  alucont_o = ALU_AND;
                    FN_OR:   alucont_o = ALU_OR;
                    FN_SLT:  alucont_o = ALU_SLT;
                    default: alucont_o = ALU_ADD;
                endcase
            end
            default: alucont_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// ---------------------------------------------------------------------------
// mips_controller
// Multicycle Moore FSM controller for an 8-bit-memory MIPS subset
// (LB, SB, R-type, BEQ, J, ADDI). The 32-bit instruction is fetched one
// byte per cycle over FETCH1..FETCH4, then decoded and executed.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; forces FETCH1 and idles all outputs
//   bus   : mips_controller_if.master (op/funct/zero in, controls out)
// Outputs decode from the state alone, except pcen in BEQEX (follows zero)
// and alucont in RTYPEEX (follows funct).
// ---------------------------------------------------------------------------
module mips_controller
    import mips_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mips_controller_if.master bus
);

    state_t     state_q;
    state_t     state_d;

    logic       pcen;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       memread;
    logic       memwrite;
    logic [3:0] irwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic [2:0] alucont;

    alu_decoder u_alu_decoder (
        .aluop_i   (aluop),
        .funct_i   (bus.funct),
        .alucont_o (alucont)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Any unexpected op in MEMADR (cannot occur with a
    // stable instruction register) falls back to FETCH1.
    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = FETCH3;
            FETCH3: state_d = FETCH4;
            FETCH4: state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LB) begin
                    state_d = LBRD;
                end else if (bus.op == OP_SB) begin
                    state_d = SBWR;
                end else begin
                    state_d = FETCH1;
                end
            end
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            default: state_d = FETCH1;
        endcase
    end

    // Output decode. While reset is held every strobe is forced idle, so the
    // FETCH1 strobes only appear once reset is released.
    always_comb begin
        pcen     = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 4'b0000;
        alusrcb  = SRCB_REG;
        pcsource = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        if (reset) begin
            case (state_q)
                FETCH1, FETCH2, FETCH3, FETCH4: begin
                    memread = 1'b1;
                    alusrcb = SRCB_ONE;
                    pcen    = 1'b1;
                    irwrite = fetch_irwrite(state_q[1:0]);
                end
                // Precompute the branch target into aluout_flop.
                DECODE: alusrcb = SRCB_IMM4;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                LBRD: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                LBWR: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                SBWR: begin
                    alusrca  = 1'b1;
                    alusrcb  = SRCB_IMM;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                RTYPEWR: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BEQEX: begin
                    alusrca  = 1'b1;
                    aluop    = ALUOP_SUB;
                    pcsource = PCSRC_FLOP;
                    pcen     = bus.zero;
                end
                JEX: begin
                    pcsource = PCSRC_JUMP;
                    pcen     = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                ADDIWR: regwrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.pcen     = pcen;
    assign bus.iord     = iord;
    assign bus.regdst   = regdst;
    assign bus.memtoreg = memtoreg;
    assign bus.regwrite = regwrite;
    assign bus.alusrca  = alusrca;
    assign bus.memread  = memread;
    assign bus.memwrite = memwrite;
    assign bus.irwrite  = irwrite;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsource = pcsource;
    assign bus.alucont  = alucont;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_controller
// Self-checking bench: each instruction is expanded into the list of
// per-cycle output vectors it must produce, and a compare process checks
// the DUT against that list on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_controller;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LB   = 6'b100000;
    localparam logic [5:0] T_SB   = 6'b101000;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, regdst, memtoreg, regwrite, alusrca, memread, memwrite;
        logic [3:0] irw;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];
    exp_t act_v;
    exp_t exp_v;

    always #5 clk = ~clk;

    mips_controller_if bus ();

    mips_controller dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic exp_t idle(input int st);
        exp_t e;
        e     = '0;
        e.st  = 4'(st);
        e.alu = 3'b010;
        return e;
    endfunction

    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected per-cycle outputs of one whole instruction.
    function automatic void build(input logic [5:0] o, input logic [5:0] f, input logic z);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = idle(i);
            e.memread = 1'b1;
            e.srcb    = 2'b01;
            e.pcen    = 1'b1;
            e.irw     = 4'b1000 >> i;
            expq.push_back(e);
        end
        e = idle(4);
        e.srcb = 2'b11;
        expq.push_back(e);
        if (o == T_LB || o == T_SB) begin
            e = idle(5);
            e.alusrca = 1'b1;
            e.srcb    = 2'b10;
            expq.push_back(e);
            e.iord = 1'b1;
            if (o == T_LB) begin
                e.st      = 4'd6;
                e.memread = 1'b1;
                expq.push_back(e);
                e = idle(7);
                e.regwrite = 1'b1;
                e.memtoreg = 1'b1;
                expq.push_back(e);
            end else begin
                e.st       = 4'd8;
                e.memwrite = 1'b1;
                expq.push_back(e);
            end
        end else if (o == T_R) begin
            e = idle(9);
            e.alusrca = 1'b1;
            e.alu     = fn_alu(f);
            expq.push_back(e);
            e = idle(10);
            e.regwrite = 1'b1;
            e.regdst   = 1'b1;
            expq.push_back(e);
        end else if (o == T_BEQ) begin
            e = idle(11);
            e.alusrca = 1'b1;
            e.alu     = 3'b110;
            e.pcsrc   = 2'b01;
            e.pcen    = z;
            expq.push_back(e);
        end else if (o == T_J) begin
            e = idle(12);
            e.pcsrc = 2'b10;
            e.pcen  = 1'b1;
            expq.push_back(e);
        end else if (o == T_ADDI) begin
            e = idle(13);
            e.alusrca = 1'b1;
            e.srcb    = 2'b10;
            expq.push_back(e);
            e = idle(14);
            e.regwrite = 1'b1;
            expq.push_back(e);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Per-cycle compare against the expected list, plus strobe exclusivity.
    always @(negedge clk) begin
        if (chk_en) begin
            act_v = {bus.state, bus.pcen, bus.iord, bus.regdst, bus.memtoreg, bus.regwrite,
                     bus.alusrca, bus.memread, bus.memwrite, bus.irwrite, bus.alusrcb,
                     bus.pcsource, bus.alucont};
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL underrun: got %h want nothing pending", act_v);
            end else begin
                exp_v = expq.pop_front();
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL cycle op=%b funct=%b zero=%b: got %h want %h (st %0d vs %0d)",
                             bus.op, bus.funct, bus.zero, act_v, exp_v, act_v.st, exp_v.st);
                end
            end
            total++;
            if ((bus.memread && bus.memwrite) || (bus.regwrite && bus.memwrite)) begin
                bad++;
                $display("FAIL exclusive strobes: got rd=%b wr=%b rw=%b want no overlap",
                         bus.memread, bus.memwrite, bus.regwrite);
            end
        end
    end

    // Call with the DUT sitting in FETCH1, just after an edge; returns 2ns
    // after the edge that starts the following instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int cyc;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        build(o, f, z);
        chk_en = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (expq.size() != 0 && cyc < 20);
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout op=%b: got %0d pending want 0", o, expq.size());
            expq.delete();
        end
        #2;
    endtask

    function automatic logic [5:0] rand_illegal();
        logic [5:0] o;
        do begin
            o = 6'($urandom_range(0, 63));
        end while (o == T_R || o == T_J || o == T_BEQ || o == T_ADDI || o == T_LB || o == T_SB);
        return o;
    endfunction

    int         cpi_req[7] = '{8, 7, 7, 7, 6, 6, 5};
    logic [5:0] cpi_op[7];
    int         lb_st[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    logic [5:0] fn_tab[5];

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        bus.op    = 6'd0;
        bus.funct = 6'd0;
        bus.zero  = 1'b0;
        cpi_op    = '{T_LB, T_SB, T_R, T_ADDI, T_BEQ, T_J, 6'b111111};
        fn_tab    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Pin the model against hand-derived numbers.
        for (int i = 0; i < 7; i++) begin
            build(cpi_op[i], 6'b100000, 1'b1);
            chk("model cpi", expq.size(), cpi_req[i]);
            expq.delete();
        end
        build(T_LB, 6'd0, 1'b0);
        for (int i = 0; i < 8; i++) chk("model lb state", expq[i].st, lb_st[i]);
        chk("model lbrd rd/iord", {expq[6].memread, expq[6].iord}, 2'b11);
        chk("model lbwr rw/m2r", {expq[7].regwrite, expq[7].memtoreg}, 2'b11);
        expq.delete();
        build(T_R, 6'b101010, 1'b0);
        chk("model slt alucont", expq[5].alu, 3'b111);
        expq.delete();
        build(T_BEQ, 6'd0, 1'b0);
        chk("model beq nz pcen", expq[5].pcen, 1'b0);
        expq.delete();

        // Reset state held over edges.
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", bus.state, 4'd0);
        chk("reset pcen", bus.pcen, 1'b0);
        chk("reset irwrite", bus.irwrite, 4'b0000);
        chk("reset alucont", bus.alucont, 3'b010);
        chk("reset strobes", {bus.iord, bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
                              bus.memread, bus.memwrite, bus.alusrcb, bus.pcsource}, 13'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed instructions.
        run_instr(T_LB, 6'b000000, 1'b0);
        run_instr(T_R, 6'b101010, 1'b0);
        run_instr(T_BEQ, 6'b000000, 1'b1);
        run_instr(T_BEQ, 6'b000000, 1'b0);
        run_instr(T_SB, 6'b000000, 1'b1);
        run_instr(6'b111111, 6'b000000, 1'b0);
        run_instr(T_J, 6'b000000, 1'b0);
        run_instr(T_ADDI, 6'b100010, 1'b1);
        for (int i = 0; i < 5; i++) run_instr(T_R, fn_tab[i], 1'b0);
        run_instr(T_R, 6'b111111, 1'b0);

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: o = T_LB;
                1: o = T_SB;
                2: o = T_R;
                3: o = T_BEQ;
                4: o = T_J;
                5: o = T_ADDI;
                default: o = rand_illegal();
            endcase
            if ($urandom_range(0, 3) == 0) f = 6'($urandom_range(0, 63));
            else f = fn_tab[$urandom_range(0, 4)];
            run_instr(o, f, 1'($urandom_range(0, 1)));
        end

        // Abort an LB in MEMADR with an asynchronous reset.
        bus.op    = T_LB;
        bus.funct = 6'd0;
        bus.zero  = 1'b1;
        build(T_LB, 6'd0, 1'b1);
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #7;
        chk_en = 1'b0;
        expq.delete();
        rst_n = 1'b0;
        #1;
        chk("abort state", bus.state, 4'd0);
        chk("abort pcen", bus.pcen, 1'b0);
        chk("abort strobes", {bus.iord, bus.memread, bus.memwrite, bus.regwrite, bus.irwrite}, 8'd0);
        @(posedge clk);
        #2;
        chk("abort hold state", bus.state, 4'd0);
        chk("abort hold alucont", bus.alucont, 3'b010);
        rst_n = 1'b1;
        #1;
        chk("release pcen", bus.pcen, 1'b1);
        chk("release irwrite", bus.irwrite, 4'b1000);
        chk("release state", bus.state, 4'd0);
        #1;
        run_instr(T_J, 6'd0, 1'b0);
        run_instr(T_ADDI, 6'd0, 1'b0);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
